// File: rtl/tag_scan_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// tag_scan_pkg : shared sizes and scan state encoding for the tag scanner
// Revision     : 1.0
//------------------------------------------------------------------------------
package tag_scan_pkg;

  localparam int TAG_W = 12;
  localparam int DEPTH = 8;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/tag_cmp.sv
`default_nettype none
//------------------------------------------------------------------------------
// tag_cmp  : combinational full-width tag equality
// Revision : 1.0
//------------------------------------------------------------------------------
module tag_cmp #(
  parameter int TAG_W = tag_scan_pkg::TAG_W
) (
  input  logic [TAG_W-1:0] i_tagA,
  input  logic [TAG_W-1:0] i_tagB,
  output logic             o_eq
);
  import tag_scan_pkg::*;

  assign o_eq = (i_tagA == i_tagB);

endmodule
`default_nettype wire

// File: rtl/tag_scan12.sv
`default_nettype none
//------------------------------------------------------------------------------
// tag_scan12 : sequential tag table search, one entry compared per cycle
//              TAG_SCAN_EARLY_EXIT_EN ends the scan right after the first hit
// Revision   : 1.0
//------------------------------------------------------------------------------
module tag_scan12 #(
  parameter int TAG_W = tag_scan_pkg::TAG_W,
  parameter int DEPTH = tag_scan_pkg::DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [TAG_W-1:0]         wr_data,
  input  logic                     search_req,
  input  logic [TAG_W-1:0]         search_key,
  output logic                     search_busy,
  output logic                     search_done,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] hit_idx
);
  import tag_scan_pkg::*;

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] c_lastPtr = PTR_W'(DEPTH - 1);

  scan_state_t      r_state;
  scan_state_t      w_stateNext;
  logic [PTR_W-1:0] r_ptr;
  logic [TAG_W-1:0] r_key;
  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tagMem [DEPTH];
  logic             r_found;
  logic [PTR_W-1:0] r_foundIdx;
  logic             r_hit;
  logic [PTR_W-1:0] r_hitIdx;
  logic             w_tagEq;
  logic             w_match;
  logic             w_exitNow;
  logic             w_accept;
  logic             w_scanEnd;

  tag_cmp #(.TAG_W(TAG_W)) u_cmp (
    .i_tagA (r_tagMem[r_ptr]),
    .i_tagB (r_key),
    .o_eq   (w_tagEq)
  );

  assign w_accept = (r_state == IDLE) && search_req;
  assign w_match  = (r_state == SCAN) && r_valid[r_ptr] && w_tagEq;

`ifdef TAG_SCAN_EARLY_EXIT_EN
  // Any match seen while scanning is the first one, since we leave on it.
  assign w_exitNow = (r_ptr == c_lastPtr) || w_match;
`else
  assign w_exitNow = (r_ptr == c_lastPtr);
`endif

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (search_req) w_stateNext = SCAN;
      SCAN:    if (w_exitNow)  w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  assign w_scanEnd = (r_state == SCAN) && (w_stateNext == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid    <= '0;
      r_ptr      <= '0;
      r_key      <= '0;
      r_found    <= 1'b0;
      r_foundIdx <= '0;
      r_hit      <= 1'b0;
      r_hitIdx   <= '0;
    end else begin
      if (wr_en) r_valid[wr_idx] <= 1'b1;
      if (w_accept) begin
        r_key      <= search_key;
        r_ptr      <= '0;
        r_found    <= 1'b0;
        r_foundIdx <= '0;
      end else if (r_state == SCAN) begin
        r_ptr <= r_ptr + PTR_W'(1);
        if (w_match && !r_found) begin
          r_found    <= 1'b1;
          r_foundIdx <= r_ptr;
        end
      end
      // The final compare is still combinational here, so fold it in directly.
      if (w_scanEnd) begin
        r_hit    <= r_found || w_match;
        r_hitIdx <= r_found ? r_foundIdx : (w_match ? r_ptr : '0);
      end
    end
  end

  // Tag data is deliberately unreset; only the valid bits gate matching.
  always_ff @(posedge clock) begin
    if (wr_en) r_tagMem[wr_idx] <= wr_data;
  end

  assign search_busy = (r_state != IDLE);
  assign search_done = (r_state == DONE);
  assign hit         = r_hit;
  assign hit_idx     = r_hitIdx;

endmodule
`default_nettype wire

// File: doc/tag_scan12.md
TAG_SCAN12 -- requirements
Module: tag_scan12

Interface
REQ-001 SHALL have parameter TAG_W, default 12, tag width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of tag entries (power of two).
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wr_en, input, 1, write entry wr_idx this cycle.
REQ-006 SHALL have port wr_idx, input, log2(DEPTH), entry index to write.
REQ-007 SHALL have port wr_data, input, TAG_W, tag value to store.
REQ-008 SHALL have port search_req, input, 1, start a search; sampled only in IDLE.
REQ-009 SHALL have port search_key, input, TAG_W, key captured with the accepted search_req.
REQ-010 SHALL have port search_busy, output, 1, high in SCAN and DONE.
REQ-011 SHALL have port search_done, output, 1, one-cycle pulse: result valid.
REQ-012 SHALL have port hit, output, 1, last completed search found a match.
REQ-013 SHALL have port hit_idx, output, log2(DEPTH), lowest matching index; 0 on miss.

Function
REQ-014 SHALL store DEPTH entries of TAG_W bits plus one valid bit each; a write sets data and valid.
REQ-015 SHALL implement states IDLE, SCAN, DONE; IDLE->SCAN on search_req, key latched, pointer cleared to 0.
REQ-016 SHALL compare exactly one entry (pointer) per SCAN cycle; match = valid AND stored tag equals latched key on all TAG_W bits.
REQ-017 SHALL go SCAN->DONE after comparing entry DEPTH-1 (or earlier per REQ-027); DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL assert search_done only in DONE, with hit/hit_idx updated in that same cycle and held until the next DONE.
REQ-019 SHALL latch only the first (lowest-index) match of a search; later matches are ignored.
REQ-020 SHALL ignore search_req while search_busy is high; no queuing.
REQ-021 SHALL apply writes in any state; an entry compared in the same cycle as its write uses old contents; a write to a not-yet-scanned entry is seen by the scan.
REQ-022 SHALL keep search_busy low in IDLE so a new request is accepted the cycle after DONE.

Reset
REQ-023 SHALL, on reset (any time, including mid-scan), force IDLE, clear all valid bits, pointer and latched key to 0.
REQ-024 SHALL drive search_busy=0, search_done=0, hit=0, hit_idx=0 during and after reset; an aborted scan produces no search_done.
REQ-025 SHALL not require tag storage data to be reset; only valid bits gate matching.

Configuration
REQ-026 SHALL use macro TAG_SCAN_EARLY_EXIT_EN.
REQ-027 SHALL, with the macro defined, go SCAN->DONE in the cycle after the first match (match at entry k, request sampled at edge N -> search_done at cycle N+k+2).
REQ-028 SHALL, with the macro undefined, always scan all entries: search_done at cycle N+DEPTH+1 (N+9 for default) regardless of hit.

Structure
REQ-029 SHALL place TAG_W, DEPTH, IDX_W and the IDLE/SCAN/DONE state encoding in shared package tag_scan_pkg.
REQ-030 SHALL instantiate one sub-module tag_cmp (TAG_W-bit equality, combinational) for the per-cycle compare.

Verification
REQ-031 SHALL cover: after reset, search key 0x000 -> search_done at N+9 (no macro), hit=0, hit_idx=0 (entries invalid).
REQ-032 SHALL cover: write 0xABC to entries 2 and 5, search 0xABC -> hit=1, hit_idx=2; with macro, done at N+4.
REQ-033 SHALL cover: search_req held high through scan -> exactly one search_done, next search accepted the cycle after DONE.
REQ-034 SHALL cover: during scan write 0x123 to entry 6 while pointer=3, key 0x123 -> hit=1, hit_idx=6; write to entry 1 at pointer=3 -> miss.
REQ-035 SHALL cover: reset asserted at pointer=4 -> no search_done, busy=0, hit=0 immediately; subsequent search of prior tag -> miss.
